// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC register, imem request/ack handshake, instruction register.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets trap to ERROR and set misalign_o.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0040_0000,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] Instruction_bus_o,
  output logic [6:0]  op_o,
  output logic [31:0] pc_o,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        misalign_o,
`endif
  output logic        fetch_error_o
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_p0, pc_d;
  logic [31:0] instr_p0, instr_d;
  logic [31:0] addr_p0, addr_d;
  logic        vld_p0, vld_d;
  logic        req_q, req_d;
  logic        flush_q, flush_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        redirect_ok;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign redirect_ok = (redirect_pc_i[1:0] == 2'b00);
  assign misalign_o  = mis_q;
`else
  assign redirect_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_p0;
    instr_d = instr_p0;
    addr_d  = addr_p0;
    vld_d   = vld_p0;
    flush_d = flush_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_d   = mis_q;
`endif

    unique case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = sat_inc(cnt_q);
        if (imem_ack_i) begin
          if (flush_q) begin
            flush_d = 1'b0;
            state_d = S_FETCH;
          end else begin
            instr_d = imem_rdata_i;
            vld_d   = 1'b1;
            state_d = S_HOLD;
          end
        end else if (cnt_q >= TIMEOUT_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          pc_d    = pc_p0 + 32'd4;
          vld_d   = 1'b0;
          instr_d = NOP_WORD;
          state_d = S_FETCH;
        end
      end
      S_ERROR: vld_d = 1'b0;
      default: state_d = S_FETCH;
    endcase

    // Redirect overrides whatever the state logic chose, including stall.
    if (redirect_i) begin
      vld_d   = 1'b0;
      instr_d = NOP_WORD;
      if (!redirect_ok) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
        flush_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_d   = 1'b1;
`endif
      end else begin
        pc_d = align_word(redirect_pc_i);
        if (state_q == S_WAIT && !imem_ack_i) begin
          // Outstanding request must still complete; its word gets dropped.
          state_d = S_WAIT;
          flush_d = 1'b1;
          err_d   = err_q;
        end else begin
          state_d = S_FETCH;
          flush_d = 1'b0;
        end
      end
    end

    if (state_d == S_WAIT && state_q != S_WAIT) begin
      cnt_d  = 8'd0;
      addr_d = pc_p0;
    end
    req_d = (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_p0    <= RESET_PC;
      instr_p0 <= NOP_WORD;
      addr_p0  <= RESET_PC;
      vld_p0   <= 1'b0;
      req_q    <= 1'b0;
      flush_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_p0    <= pc_d;
      instr_p0 <= instr_d;
      addr_p0  <= addr_d;
      vld_p0   <= vld_d;
      req_q    <= req_d;
      flush_q  <= flush_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q    <= mis_d;
`endif
    end
  end

  assign imem_req_o        = req_q;
  assign imem_addr_o       = addr_p0;
  assign instr_valid_o     = vld_p0;
  assign Instruction_bus_o = instr_p0;
  assign op_o              = instr_p0[6:0];
  assign pc_o              = pc_p0;
  assign fetch_error_o     = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: table-driven fetch vectors with a scoreboard, plus redirect/timeout/wrap/reset sequences.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, reset, stall_i, redirect_i, imem_ack_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, instr_valid_o, fetch_error_o;
  logic [31:0] imem_addr_o, Instruction_bus_o, pc_o;
  logic [6:0]  op_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [31:0] model_pc;

  typedef struct {
    int          delay;
    logic [31:0] word;
    logic [6:0]  op;
    int          stall;
  } vec_t;
  vec_t vecs[4];

  instruction_fetch_unit #(
    .RESET_PC(RESET_PC), .TIMEOUT_CYCLES(16), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .instr_valid_o(instr_valid_o),
    .Instruction_bus_o(Instruction_bus_o), .op_o(op_o), .pc_o(pc_o),
    .fetch_error_o(fetch_error_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req;
    int n = 0;
    while (!imem_req_o && n < 20) begin
      tick();
      n++;
    end
    check("req_arrives", {31'b0, imem_req_o}, 32'd1);
  endtask

  task automatic do_fetch(input int delay, input logic [31:0] word, input logic [6:0] op,
                          input int stall);
    logic [63:0] e;
    wait_req();
    check("fetch_addr", imem_addr_o, model_pc);
    check("valid_low_in_wait", {31'b0, instr_valid_o}, 32'd0);
    repeat (delay) tick();
    check("req_held", {31'b0, imem_req_o}, 32'd1);
    imem_ack_i   = 1'b1;
    imem_rdata_i = word;
    stall_i      = (stall > 0);
    sb_q.push_back({model_pc, word});
    tick();
    imem_ack_i   = 1'b0;
    imem_rdata_i = $urandom;
    check("valid_rise", {31'b0, instr_valid_o}, 32'd1);
    check("req_drop", {31'b0, imem_req_o}, 32'd0);
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("instr_bus", Instruction_bus_o, e[31:0]);
      check("instr_pc", pc_o, e[63:32]);
    end
    check("op", {25'b0, op_o}, {25'b0, op});
    for (int k = 0; k < stall; k++) begin
      tick();
      check("stall_bus", Instruction_bus_o, word);
      check("stall_pc", pc_o, model_pc);
      check("stall_valid", {31'b0, instr_valid_o}, 32'd1);
      check("stall_req", {31'b0, imem_req_o}, 32'd0);
    end
    stall_i = 1'b0;
    tick();
    check("consume_valid", {31'b0, instr_valid_o}, 32'd0);
    check("consume_bus", Instruction_bus_o, NOP);
    check("consume_pc", pc_o, model_pc + 32'd4);
    model_pc = model_pc + 32'd4;
  endtask

  initial begin
    int n;
    vecs[0] = '{delay: 0, word: 32'h0050_0093, op: 7'h13, stall: 0};
    vecs[1] = '{delay: 0, word: 32'h0010_8113, op: 7'h13, stall: 3};
    vecs[2] = '{delay: 2, word: 32'h0020_81B3, op: 7'h33, stall: 1};
    vecs[3] = '{delay: 5, word: 32'hFFF0_0513, op: 7'h13, stall: 0};

    reset = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    #8;
    check("rst_pc", pc_o, RESET_PC);
    check("rst_bus", Instruction_bus_o, NOP);
    check("rst_op", {25'b0, op_o}, 32'h13);
    check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_err", {31'b0, fetch_error_o}, 32'd0);
    #5 reset = 1'b1;

    model_pc = RESET_PC;
    for (int i = 0; i < 4; i++) do_fetch(vecs[i].delay, vecs[i].word, vecs[i].op, vecs[i].stall);

    // Redirect while a request is outstanding; the late word must be dropped.
    wait_req();
    check("flush_addr", imem_addr_o, model_pc);
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0100;
    tick();
    redirect_i = 1'b0;
    check("flush_pc", pc_o, 32'h0040_0100);
    check("flush_req_kept", {31'b0, imem_req_o}, 32'd1);
    check("flush_valid", {31'b0, instr_valid_o}, 32'd0);
    tick();
    imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_ack_i = 1'b0;
    check("flush_drop_valid", {31'b0, instr_valid_o}, 32'd0);
    check("flush_drop_bus", Instruction_bus_o, NOP);
    model_pc = 32'h0040_0100;
    do_fetch(0, 32'h00A0_0113, 7'h13, 0);

    // Redirect coinciding with ack; low target bits are cleared.
    wait_req();
    check("rack_addr", imem_addr_o, model_pc);
    imem_ack_i = 1'b1; imem_rdata_i = 32'hCAFE_F00D;
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0202;
    tick();
    imem_ack_i = 1'b0; redirect_i = 1'b0;
    check("rack_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rack_bus", Instruction_bus_o, NOP);
    check("rack_pc", pc_o, 32'h0040_0200);

    // Timeout: no ack at all.
    wait_req();
    check("to_addr", imem_addr_o, 32'h0040_0200);
    check("to_err_before", {31'b0, fetch_error_o}, 32'd0);
    n = 0;
    while (imem_req_o && n < 40) begin
      n++;
      tick();
    end
    check("to_wait_cycles", n, 32'd16);
    check("to_err", {31'b0, fetch_error_o}, 32'd1);
    check("to_req", {31'b0, imem_req_o}, 32'd0);
    check("to_valid", {31'b0, instr_valid_o}, 32'd0);
    tick();
    check("to_stays_idle", {31'b0, imem_req_o}, 32'd0);
    redirect_i = 1'b1; redirect_pc_i = RESET_PC;
    tick();
    redirect_i = 1'b0;
    check("err_exit_pc", pc_o, RESET_PC);
    check("err_sticky", {31'b0, fetch_error_o}, 32'd1);
    model_pc = RESET_PC;
    do_fetch(1, 32'h0000_0297, 7'h17, 0);
    check("err_sticky2", {31'b0, fetch_error_o}, 32'd1);

    // PC wrap at the top of the address space.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    model_pc = 32'hFFFF_FFFC;
    do_fetch(0, 32'h0000_006F, 7'h6F, 0);
    wait_req();
    check("wrap_addr", imem_addr_o, 32'h0000_0000);

    // Asynchronous reset in the middle of WAIT.
    #2 reset = 1'b0;
    #1;
    check("arst_pc", pc_o, RESET_PC);
    check("arst_bus", Instruction_bus_o, NOP);
    check("arst_op", {25'b0, op_o}, 32'h13);
    check("arst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("arst_req", {31'b0, imem_req_o}, 32'd0);
    check("arst_err", {31'b0, fetch_error_o}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
